led_pattern_gen: RTL and testbench

Produces the three 4-LED patterns (single shift, double bounce, flash) that feed the sequence mux's i_shift_leds, i_shift2_leds and i_flash_leds inputs.
A prescaler with a selectable rate advances all three patterns in lockstep.
It is the source side of the mux's pattern-input interface and sits between the board clock and the mux.

---
 rtl/led_pattern_gen.sv | 115 +++++++++++
 tb/tb_led_pattern_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Free-running LED pattern source: a rate-selectable prescaler advances the
// rotating one-hot, bouncing pair and flash patterns together on each tick.
module led_pattern_gen #(
    parameter int          N_LEDS = 4,
    parameter int          CNT_W  = 32,
    parameter int unsigned LIMIT0 = 2**23 - 1,
    parameter int unsigned LIMIT1 = 2**22 - 1,
    parameter int unsigned LIMIT2 = 2**21 - 1,
    parameter int unsigned LIMIT3 = 2**20 - 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [1:0]        i_speed_sel,
    input  logic              i_dir,
    output logic [N_LEDS-1:0] o_shift_leds,
    output logic [N_LEDS-1:0] o_shift2_leds,
    output logic [N_LEDS-1:0] o_flash_leds,
    output logic              o_tick
);

    typedef enum logic {
        BOUNCE_UP,
        BOUNCE_DOWN
    } bounce_t;

    localparam logic [N_LEDS-1:0] SHIFT_RST = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] PAIR_RST  = {{(N_LEDS-2){1'b0}}, 2'b11};

    logic [CNT_W-1:0]  cnt_q, cnt_d, limit;
    logic [1:0]        speed_q, speed_d;
    logic              tick_q, tick_d;
    logic [N_LEDS-1:0] shift_q, shift_d;
    logic [N_LEDS-1:0] pair_q, pair_d;
    logic [N_LEDS-1:0] flash_q, flash_d;
    bounce_t           bounce_q, bounce_d;
    logic              speed_change;

    always_comb begin
        case (i_speed_sel)
            2'd0:    limit = CNT_W'(LIMIT0);
            2'd1:    limit = CNT_W'(LIMIT1);
            2'd2:    limit = CNT_W'(LIMIT2);
            default: limit = CNT_W'(LIMIT3);
        endcase
    end

    assign speed_change = (speed_q != i_speed_sel);

    // speed_q only tracks the input while enabled, so a change made during a
    // freeze is still seen (and clears the counter) on the first enabled cycle.
    always_comb begin
        cnt_d    = cnt_q;
        speed_d  = speed_q;
        tick_d   = 1'b0;
        shift_d  = shift_q;
        pair_d   = pair_q;
        flash_d  = flash_q;
        bounce_d = bounce_q;
        if (i_enable) begin
            speed_d = i_speed_sel;
            if (speed_change) begin
                cnt_d = '0;
            end else if (cnt_q == limit) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                flash_d = ~flash_q;
                if (i_dir)
                    shift_d = {shift_q[0], shift_q[N_LEDS-1:1]};
                else
                    shift_d = {shift_q[N_LEDS-2:0], shift_q[N_LEDS-1]};
                case (bounce_q)
                    BOUNCE_UP: begin
                        pair_d = pair_q << 1;
                        if (pair_d[N_LEDS-1])
                            bounce_d = BOUNCE_DOWN;
                    end
                    default: begin
                        pair_d = pair_q >> 1;
                        if (pair_d[0])
                            bounce_d = BOUNCE_UP;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q    <= '0;
            speed_q  <= 2'd0;
            tick_q   <= 1'b0;
            shift_q  <= SHIFT_RST;
            pair_q   <= PAIR_RST;
            flash_q  <= '0;
            bounce_q <= BOUNCE_UP;
        end else begin
            cnt_q    <= cnt_d;
            speed_q  <= speed_d;
            tick_q   <= tick_d;
            shift_q  <= shift_d;
            pair_q   <= pair_d;
            flash_q  <= flash_d;
            bounce_q <= bounce_d;
        end
    end

    assign o_shift_leds  = shift_q;
    assign o_shift2_leds = pair_q;
    assign o_flash_leds  = flash_q;
    assign o_tick        = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen with short prescaler limits 3/7/15/31.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_enable = 1'b1;
    logic [1:0] i_speed_sel = 2'd0;
    logic       i_dir = 1'b0;
    logic [3:0] o_shift_leds, o_shift2_leds, o_flash_leds;
    logic       o_tick;

    int tests = 0;
    int fails = 0;
    int tick_no = 0;

    typedef struct packed {
        logic [3:0] sh;
        logic [3:0] s2;
        logic [3:0] fl;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LEDS(4), .CNT_W(32),
        .LIMIT0(3), .LIMIT1(7), .LIMIT2(15), .LIMIT3(31)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_speed_sel  (i_speed_sel),
        .i_dir        (i_dir),
        .o_shift_leds (o_shift_leds),
        .o_shift2_leds(o_shift2_leds),
        .o_flash_leds (o_flash_leds),
        .o_tick       (o_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] sh, input logic [3:0] s2, input logic [3:0] fl);
        exp_t e;
        e.sh = sh;
        e.s2 = s2;
        e.fl = fl;
        sb_q.push_back(e);
    endtask

    // Counts falling edges until o_tick is seen; bounded so a dead DUT still ends.
    task automatic wait_tick(input string name, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_tick && n < 100);
        check(name, n, exp_n);
    endtask

    // Monitor: every tick pops one expected pattern set.
    always @(negedge clk) begin
        if (i_rst && o_tick) begin
            tick_no++;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_tick #%0d: tick=1 required 0", tick_no);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("tick%0d_shift", tick_no),  o_shift_leds,  mon_e.sh);
                check($sformatf("tick%0d_shift2", tick_no), o_shift2_leds, mon_e.s2);
                check($sformatf("tick%0d_flash", tick_no),  o_flash_leds,  mon_e.fl);
                $display("[TB] tick %0d shift=%b shift2=%b flash=%b", tick_no,
                         o_shift_leds, o_shift2_leds, o_flash_leds);
            end
        end
    end

    initial begin
        int ticks_seen;

        // Reset state, then first tick 4 cycles after release.
        #1 i_rst = 1'b0;
        #2;
        check("rst_shift",  o_shift_leds,  4'b0001);
        check("rst_shift2", o_shift2_leds, 4'b0011);
        check("rst_flash",  o_flash_leds,  4'b0000);
        check("rst_tick",   o_tick,        1'b0);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;

        push(4'b0010, 4'b0110, 4'b1111); wait_tick("first_tick_latency", 4);
        push(4'b0100, 4'b1100, 4'b0000); wait_tick("period_t2", 4);
        push(4'b1000, 4'b0110, 4'b1111); wait_tick("period_t3", 4);
        push(4'b0001, 4'b0011, 4'b0000); wait_tick("period_t4", 4);
        push(4'b0010, 4'b0110, 4'b1111); wait_tick("period_t5", 4);

        i_dir = 1'b1;
        push(4'b0001, 4'b1100, 4'b0000); wait_tick("period_t6", 4);
        push(4'b1000, 4'b0110, 4'b1111); wait_tick("period_t7", 4);
        i_dir = 1'b0;

        // Freeze mid-count with the counter at 2.
        repeat (2) @(negedge clk);
        i_enable = 1'b0;
        ticks_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_tick) ticks_seen++;
        end
        check("hold_no_tick", ticks_seen, 0);
        check("hold_shift",  o_shift_leds,  4'b1000);
        check("hold_shift2", o_shift2_leds, 4'b0110);
        check("hold_flash",  o_flash_leds,  4'b1111);
        i_enable = 1'b1;
        push(4'b0001, 4'b0011, 4'b0000); wait_tick("resume_remaining", 2);

        // Speed 0 -> 3, let the counter reach 20, then back to 0.
        i_speed_sel = 2'd3;
        repeat (21) @(negedge clk);
        i_speed_sel = 2'd0;
        push(4'b0010, 4'b0110, 4'b1111); wait_tick("speed_change_restart", 5);

        // Speed change landing on the terminal count suppresses the tick.
        repeat (3) @(negedge clk);
        i_speed_sel = 2'd1;
        @(negedge clk);
        check("coincide_tick",  o_tick,       1'b0);
        check("coincide_shift", o_shift_leds, 4'b0010);
        check("coincide_flash", o_flash_leds, 4'b1111);
        push(4'b0100, 4'b1100, 4'b0000); wait_tick("limit1_period", 8);

        // Asynchronous reset in the low phase, checked before the next rising edge.
        #2 i_rst = 1'b0;
        i_speed_sel = 2'd0;
        #1;
        check("async_rst_shift",  o_shift_leds,  4'b0001);
        check("async_rst_shift2", o_shift2_leds, 4'b0011);
        check("async_rst_flash",  o_flash_leds,  4'b0000);
        check("async_rst_tick",   o_tick,        1'b0);
        @(negedge clk);
        i_rst = 1'b1;
        push(4'b0010, 4'b0110, 4'b1111); wait_tick("post_reset_latency", 4);

        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
